// File: rtl/pixel_write_scheduler_if.sv
// pixel_write_scheduler_if: command, clear and pixel-write bus of the pixel write scheduler
interface pixel_write_scheduler_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_x;
    logic [7:0] cmd_y;
    logic [2:0] cmd_color;
    logic       cmd_brush;
    logic       clear_req;
    logic [2:0] clear_color;
    logic       wr_allow;
    logic       wr_en;
    logic [7:0] wr_x;
    logic [7:0] wr_y;
    logic [2:0] wr_color;
    logic       busy;
    logic       clearing;

    modport master (
        output cmd_valid, cmd_x, cmd_y, cmd_color, cmd_brush, clear_req, clear_color, wr_allow,
        input  cmd_ready, wr_en, wr_x, wr_y, wr_color, busy, clearing
    );

    modport slave (
        input  cmd_valid, cmd_x, cmd_y, cmd_color, cmd_brush, clear_req, clear_color, wr_allow,
        output cmd_ready, wr_en, wr_x, wr_y, wr_color, busy, clearing
    );
endinterface

// File: rtl/pixel_write_scheduler.sv
// pixel_write_scheduler: queues draw commands and full-frame clears into a gated pixel write port
module pixel_write_scheduler #(
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 120,
    parameter int DEPTH  = 4
) (
    input logic                      i_clk,
    input logic                      i_reset,
    pixel_write_scheduler_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [8:0] W9 = 9'(WIDTH);
    localparam logic [8:0] H9 = 9'(HEIGHT);
    localparam logic [7:0] XL = 8'(WIDTH - 1);
    localparam logic [7:0] YL = 8'(HEIGHT - 1);

    typedef enum logic [1:0] {S_IDLE, S_PAINT, S_CLEAR} state_t;

    state_t      r_state;
    logic [19:0] r_mem [DEPTH];
    logic [AW-1:0] r_wp, r_rp;
    logic [AW:0] r_cnt;
    logic        r_pend;
    logic [2:0]  r_ccol;
    logic [7:0]  r_x, r_y, r_cx, r_cy;
    logic [2:0]  r_col;
    logic [3:0]  r_mask;
    logic        r_wr_en;
    logic [7:0]  r_wr_x, r_wr_y;
    logic [2:0]  r_wr_color;

    logic        w_full, w_enq, w_pop, w_clr;
    logic [19:0] w_head;
    logic [7:0]  w_hx, w_hy;
    logic [2:0]  w_hc;
    logic        w_hb;
    logic        w_xin0, w_xin1, w_yin0, w_yin1;
    logic [3:0]  w_mask, w_mnext;
    logic [1:0]  w_k;

    // FIFO occupancy and handshakes; the FSM only advances while the write port is granted
    assign w_full = r_cnt == (AW+1)'(DEPTH);
    assign w_enq  = bus.cmd_valid && !w_full;
    assign w_clr  = r_pend || bus.clear_req;
    assign w_pop  = bus.wr_allow && r_state == S_IDLE && !w_clr && r_cnt != '0;

    // Head decode: sums are 9 bits so x=255 plus one lands out of range instead of wrapping
    assign w_head = r_mem[r_rp];
    assign {w_hx, w_hy, w_hc, w_hb} = w_head;
    assign w_xin0 = {1'b0, w_hx} < W9;
    assign w_xin1 = {1'b0, w_hx} + 9'd1 < W9;
    assign w_yin0 = {1'b0, w_hy} < H9;
    assign w_yin1 = {1'b0, w_hy} + 9'd1 < H9;
    assign w_mask = {w_hb & w_xin1 & w_yin1, w_hb & w_xin0 & w_yin1, w_hb & w_xin1 & w_yin0, w_xin0 & w_yin0};

    // Next sub-pixel is the lowest remaining mask bit, so clipped ones cost no cycles
    assign w_k     = r_mask[0] ? 2'd0 : r_mask[1] ? 2'd1 : r_mask[2] ? 2'd2 : 2'd3;
    assign w_mnext = r_mask & ~(4'b1 << w_k);

    // Command storage, left unreset since occupancy is tracked by the pointers
    always_ff @(posedge i_clk) begin
        if (w_enq)
            r_mem[r_wp] <= {bus.cmd_x, bus.cmd_y, bus.cmd_color, bus.cmd_brush};
    end

    // FIFO pointers, clear capture and the IDLE/PAINT/CLEAR sequencer with registered write port
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state    <= S_IDLE;
            r_wp       <= '0;
            r_rp       <= '0;
            r_cnt      <= '0;
            r_pend     <= 1'b0;
            r_ccol     <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_col      <= '0;
            r_mask     <= '0;
            r_cx       <= '0;
            r_cy       <= '0;
            r_wr_en    <= 1'b0;
            r_wr_x     <= '0;
            r_wr_y     <= '0;
            r_wr_color <= '0;
        end else begin
            r_wr_en <= 1'b0;
            if (w_enq)
                r_wp <= r_wp + 1'b1;
            if (w_pop)
                r_rp <= r_rp + 1'b1;
            r_cnt <= r_cnt + (AW+1)'(w_enq) - (AW+1)'(w_pop);
            if (bus.clear_req && !r_pend) begin
                r_pend <= 1'b1;
                r_ccol <= bus.clear_color;
            end
            if (bus.wr_allow) begin
                case (r_state)
                    S_IDLE: begin
                        if (w_clr) begin
                            r_state <= S_CLEAR;
                            r_cx    <= '0;
                            r_cy    <= '0;
                        end else if (r_cnt != '0) begin
                            r_x     <= w_hx;
                            r_y     <= w_hy;
                            r_col   <= w_hc;
                            r_mask  <= w_mask;
                            r_state <= w_mask != '0 ? S_PAINT : S_IDLE;
                        end
                    end
                    S_PAINT: begin
                        r_wr_en    <= 1'b1;
                        r_wr_x     <= r_x + {7'd0, w_k[0]};
                        r_wr_y     <= r_y + {7'd0, w_k[1]};
                        r_wr_color <= r_col;
                        r_mask     <= w_mnext;
                        if (w_mnext == '0)
                            r_state <= S_IDLE;
                    end
                    S_CLEAR: begin
                        r_wr_en    <= 1'b1;
                        r_wr_x     <= r_cx;
                        r_wr_y     <= r_cy;
                        r_wr_color <= r_ccol;
                        r_cx       <= r_cx == XL ? 8'd0 : r_cx + 8'd1;
                        if (r_cx == XL) begin
                            r_cy <= r_cy == YL ? 8'd0 : r_cy + 8'd1;
                            if (r_cy == YL) begin
                                r_state <= S_IDLE;
                                r_pend  <= 1'b0;
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.cmd_ready = !w_full;
    assign bus.busy      = r_cnt != '0 || r_state != S_IDLE;
    assign bus.clearing  = r_state == S_CLEAR;
    assign bus.wr_en     = r_wr_en;
    assign bus.wr_x      = r_wr_x;
    assign bus.wr_y      = r_wr_y;
    assign bus.wr_color  = r_wr_color;
endmodule

// File: tb/tb_pixel_write_scheduler.sv
// tb_pixel_write_scheduler: directed checks of latency, clipping, back-pressure, clear and reset
module tb_pixel_write_scheduler;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int n_chk = 0;
    int n_fail = 0;
    logic [18:0] wq[$];

    always #5 clk = ~clk;

    pixel_write_scheduler_if bus();

    pixel_write_scheduler #(.WIDTH(160), .HEIGHT(120), .DEPTH(4)) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (bus)
    );

    // Record every issued write in order
    always @(negedge clk) begin
        if (bus.wr_en)
            wq.push_back({bus.wr_x, bus.wr_y, bus.wr_color});
    end

    function automatic logic [18:0] px(input int x, input int y, input int c);
        return {8'(x), 8'(y), 3'(c)};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int x, input int y, input int c, input int b);
        bus.cmd_x     = 8'(x);
        bus.cmd_y     = 8'(y);
        bus.cmd_color = 3'(c);
        bus.cmd_brush = 1'(b);
        bus.cmd_valid = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int lim);
        int n = 0;
        while (bus.busy && n < lim) begin
            tick();
            n++;
        end
        check(tag, 32'(bus.busy), 32'd0);
        tick();
        tick();
    endtask

    task automatic check_clear(input string tag, input int base, input int c);
        int e = 0;
        for (int i = 0; i < 19200; i++)
            if (wq[base + i] !== px(i % 160, i / 160, c))
                e++;
        check(tag, 32'(e), 32'd0);
    endtask

    initial begin
        logic [18:0] ex[7];
        int acc, n, se, s;
        logic a;
        bus.cmd_valid   = 1'b0;
        bus.cmd_x       = '0;
        bus.cmd_y       = '0;
        bus.cmd_color   = '0;
        bus.cmd_brush   = 1'b0;
        bus.clear_req   = 1'b0;
        bus.clear_color = '0;
        bus.wr_allow    = 1'b1;
        tick();
        tick();
        check("rst_wr_en", 32'(bus.wr_en), 32'd0);
        check("rst_wr_x", 32'(bus.wr_x), 32'd0);
        check("rst_wr_y", 32'(bus.wr_y), 32'd0);
        check("rst_wr_color", 32'(bus.wr_color), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_clearing", 32'(bus.clearing), 32'd0);
        check("rst_ready", 32'(bus.cmd_ready), 32'd1);
        reset = 1'b1;
        tick();

        // Single pixel: write lands two edges after the accepting edge
        send(10, 20, 5, 0);
        check("lat_n", 32'(bus.wr_en), 32'd0);
        tick();
        check("lat_n1", 32'(bus.wr_en), 32'd0);
        tick();
        check("px_en", 32'(bus.wr_en), 32'd1);
        check("px_x", 32'(bus.wr_x), 32'd10);
        check("px_y", 32'(bus.wr_y), 32'd20);
        check("px_color", 32'(bus.wr_color), 32'd5);
        tick();
        check("px_en_off", 32'(bus.wr_en), 32'd0);
        check("px_busy", 32'(bus.busy), 32'd0);
        tick();
        check("px_count", 32'(wq.size()), 32'd1);

        // Brush and clipping
        wq.delete();
        send(159, 119, 7, 1);
        wait_idle("clip_corner_idle", 20);
        send(255, 5, 3, 1);
        wait_idle("clip_far_idle", 20);
        send(40, 50, 6, 1);
        wait_idle("brush_idle", 20);
        send(20, 119, 1, 1);
        wait_idle("clip_bottom_idle", 20);
        ex = '{px(159, 119, 7), px(40, 50, 6), px(41, 50, 6), px(40, 51, 6), px(41, 51, 6),
               px(20, 119, 1), px(21, 119, 1)};
        check("brush_count", 32'(wq.size()), 32'd7);
        for (int i = 0; i < 7; i++)
            check($sformatf("brush_wr%0d", i), 32'(wq[i]), 32'(ex[i]));

        // Back-pressure with the write port withheld
        wq.delete();
        bus.wr_allow = 1'b0;
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            bus.cmd_x     = 8'(i * 10 + 1);
            bus.cmd_y     = 8'(i * 3 + 2);
            bus.cmd_color = 3'(i + 1);
            bus.cmd_brush = 1'b0;
            bus.cmd_valid = 1'b1;
            if (bus.cmd_ready)
                acc++;
            tick();
        end
        bus.cmd_valid = 1'b0;
        check("bp_accepted", 32'(acc), 32'd4);
        check("bp_ready_low", 32'(bus.cmd_ready), 32'd0);
        check("bp_no_writes", 32'(wq.size()), 32'd0);
        bus.wr_allow = 1'b1;
        wait_idle("bp_idle", 50);
        check("bp_ready_back", 32'(bus.cmd_ready), 32'd1);
        check("bp_count", 32'(wq.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            check($sformatf("bp_wr%0d", i), 32'(wq[i]), 32'(px(i * 10 + 1, i * 3 + 2, i + 1)));

        // Clear requested mid-brush: brush completes, clear follows, then queued command
        wq.delete();
        send(30, 40, 4, 1);
        tick();
        bus.clear_req   = 1'b1;
        bus.clear_color = 3'd2;
        tick();
        bus.clear_req = 1'b0;
        repeat (9) tick();
        check("clr_clearing", 32'(bus.clearing), 32'd1);
        bus.clear_req   = 1'b1;
        bus.clear_color = 3'd5;
        tick();
        bus.clear_req = 1'b0;
        send(70, 80, 1, 0);
        wait_idle("clr_idle", 25000);
        check("clr_count", 32'(wq.size()), 32'd19205);
        check("clr_b0", 32'(wq[0]), 32'(px(30, 40, 4)));
        check("clr_b1", 32'(wq[1]), 32'(px(31, 40, 4)));
        check("clr_b2", 32'(wq[2]), 32'(px(30, 41, 4)));
        check("clr_b3", 32'(wq[3]), 32'(px(31, 41, 4)));
        check_clear("clr_seq", 4, 2);
        check("clr_tail", 32'(wq[19204]), 32'(px(70, 80, 1)));
        check("clr_done_flag", 32'(bus.clearing), 32'd0);

        // Clear with the grant toggling every cycle
        wq.delete();
        bus.clear_req   = 1'b1;
        bus.clear_color = 3'd6;
        tick();
        bus.clear_req = 1'b0;
        n = 0;
        se = 0;
        while (bus.busy && n < 50000) begin
            bus.wr_allow = ~bus.wr_allow;
            a = bus.wr_allow;
            tick();
            if (!a && bus.wr_en)
                se++;
            n++;
        end
        check("stall_idle", 32'(bus.busy), 32'd0);
        bus.wr_allow = 1'b1;
        tick();
        tick();
        check("stall_gated", 32'(se), 32'd0);
        check("stall_count", 32'(wq.size()), 32'd19200);
        check_clear("stall_seq", 0, 6);

        // Clear and command together, then reset partway through the clear
        wq.delete();
        bus.clear_req   = 1'b1;
        bus.clear_color = 3'd3;
        bus.cmd_x       = 8'd1;
        bus.cmd_y       = 8'd1;
        bus.cmd_color   = 3'd1;
        bus.cmd_brush   = 1'b0;
        bus.cmd_valid   = 1'b1;
        tick();
        bus.clear_req = 1'b0;
        bus.cmd_valid = 1'b0;
        n = 0;
        while (wq.size() < 500 && n < 2000) begin
            tick();
            n++;
        end
        check("rst_reach500", 32'(wq.size() >= 500), 32'd1);
        check("rst_first_clear", 32'(wq[0]), 32'(px(0, 0, 3)));
        reset = 1'b0;
        tick();
        check("rstm_wr_en", 32'(bus.wr_en), 32'd0);
        check("rstm_busy", 32'(bus.busy), 32'd0);
        check("rstm_clearing", 32'(bus.clearing), 32'd0);
        check("rstm_ready", 32'(bus.cmd_ready), 32'd1);
        s = wq.size();
        reset = 1'b1;
        repeat (5) tick();
        check("rstm_no_writes", 32'(wq.size()), 32'(s));
        check("rstm_fifo_empty", 32'(bus.busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pixel_write_scheduler.md
PIXEL_WRITE_SCHEDULER -- requirements
Module: pixel_write_scheduler

Interface
REQ-001 The block SHALL have parameter WIDTH, default 160, drawable columns (x range 0..WIDTH-1).
REQ-002 The block SHALL have parameter HEIGHT, default 120, drawable rows (y range 0..HEIGHT-1).
REQ-003 The block SHALL have parameter DEPTH, default 4, command FIFO entries (power of two).
REQ-004 clk  in  1  system clock; the only clock.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 cmd_valid  in  1  draw command present.
REQ-007 cmd_ready  out  1  FIFO can accept; high when FIFO not full.
REQ-008 cmd_x, cmd_y  in  8 each  command pixel coordinates.
REQ-009 cmd_color  in  3  command color code.
REQ-010 cmd_brush  in  1  0 = single pixel, 1 = 2x2 block anchored at (x,y).
REQ-011 clear_req  in  1  one-cycle request to fill the frame with clear_color.
REQ-012 clear_color  in  3  fill color, captured when clear_req is accepted.
REQ-013 wr_allow  in  1  write-port grant from the display side (e.g. blanking); no write issued while low.
REQ-014 wr_en  out  1  registered write strobe to the pixel store.
REQ-015 wr_x, wr_y  out  8 each  registered write address.
REQ-016 wr_color  out  3  registered write data.
REQ-017 busy  out  1  high when FIFO non-empty or state is not IDLE.
REQ-018 clearing  out  1  high while state is CLEAR.

Function
REQ-019 A command SHALL be enqueued on any cycle with cmd_valid && cmd_ready; FIFO order is strictly first-in first-out.
REQ-020 States: IDLE, PAINT, CLEAR; all outputs registered.
REQ-021 IDLE: if clear pending -> CLEAR; else if FIFO non-empty -> pop head, go PAINT; else stay.
REQ-022 PAINT issues sub-pixels in order (x,y), (x+1,y), (x,y+1), (x+1,y+1); for cmd_brush=0 only (x,y).
REQ-023 A sub-pixel with x>=WIDTH or y>=HEIGHT SHALL be skipped in zero cycles (clipping); a command whose anchor is out of range produces no writes.
REQ-024 Coordinate sums SHALL be computed 9 bits wide; x=255 with brush SHALL NOT wrap to column 0.
REQ-025 PAINT -> IDLE after the last in-range sub-pixel is written; each write consumes one cycle with wr_allow high.
REQ-026 clear_req SHALL set a pending flag and capture clear_color; a clear_req while pending or in CLEAR SHALL be ignored.
REQ-027 A pending clear SHALL NOT abort PAINT; it starts at the next IDLE, ahead of queued commands.
REQ-028 CLEAR writes every pixel once, row-major from (0,0) to (WIDTH-1,HEIGHT-1), one per allowed cycle, then returns to IDLE and clears the pending flag.
REQ-029 FIFO SHALL keep accepting commands during CLEAR and PAINT until full.
REQ-030 When wr_allow is low, wr_en SHALL be 0 and state, sub-pixel index and clear counters SHALL hold.
REQ-031 Latency: command accepted in cycle N into an empty FIFO, IDLE, wr_allow high -> wr_en high in cycle N+2 (N+1 enqueue/pop, N+2 write).
REQ-032 Simultaneous clear_req and command accept: command is enqueued and the clear runs first.
REQ-033 Simultaneous enqueue and pop on a full FIFO SHALL NOT occur (cmd_ready low); on a non-full FIFO both SHALL take effect.

Reset
REQ-034 On clk edge with reset low: FIFO emptied, state IDLE, clear pending cleared, counters zero.
REQ-035 Reset values: wr_en=0, wr_x=0, wr_y=0, wr_color=0, busy=0, clearing=0, cmd_ready=1 (from the cycle after reset).
REQ-036 Reset asserted mid-PAINT or mid-CLEAR SHALL abort the operation with no further writes.

Verification
REQ-037 Single pixel: cmd (10,20,color 5,brush 0), wr_allow=1 -> exactly one wr_en at (10,20,5), two cycles after accept; busy falls next cycle.
REQ-038 Brush clipping: cmd (159,119,brush 1) -> one write at (159,119); cmd (255,5,brush 1) -> no writes.
REQ-039 Back-pressure: 5 commands back-to-back with wr_allow=0 -> 4 accepted, cmd_ready=0; raise wr_allow -> writes in input order, cmd_ready returns.
REQ-040 Clear priority: clear_req (color 2) during a brush PAINT -> brush finishes all 4 writes, then 19200 writes of color 2 row-major, then queued commands.
REQ-041 Stall: toggle wr_allow every cycle during CLEAR -> no address skipped or repeated; total writes 19200.
REQ-042 Reset mid-CLEAR at pixel 500 -> wr_en=0 next cycle, busy=0, clearing=0, FIFO empty.
